serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor for the digital-logic lab datapath. It is the inverse operation of the lab's 4-bit ripple-carry adder. It reuses a single full-adder cell with inverted subtrahend and carry-in of 1, processing one bit per clock LSB-first. On completion it presents the difference, borrow and zero flags for display on the board LEDs. It sits between the switch-sampled operand registers and the LED driver, and trades area for WIDTH cycles of latency.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while idle
- a  input  WIDTH  minuend, captured on the accepted start edge
- b  input  WIDTH  subtrahend, captured on the accepted start edge
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when the result updates
- diff  output  WIDTH  (a − b) mod 2^WIDTH, held until next completion
- borrow  output  1  1 when a < b (unsigned), held with diff
- zero  output  1  1 when diff == 0, held with diff

## Operation
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, diff=0, borrow=0, zero=0; shift registers, carry and counter cleared. An in-flight operation is discarded and produces no done.
- States: IDLE, SHIFT. There is no separate DONE state: done is registered on the final SHIFT edge.
- IDLE, start=1 at an edge:
  - a_sh←a, b_sh←b, carry←1, cnt←0, busy←1, state←SHIFT.
  - diff, borrow and zero keep their old values.
- IDLE, start=0: hold. done←0.
- SHIFT, each edge:
  - s = a_sh[0] ^ ~b_sh[0] ^ carry.
  - cout = majority(a_sh[0], ~b_sh[0], carry).
  - carry←cout; res←{s, res[WIDTH-1:1]}; a_sh and b_sh shift right by one; cnt←cnt+1.
- SHIFT, edge where cnt==WIDTH-1:
  - diff←{s, res[WIDTH-1:1]}; borrow←~cout; zero←(that value == 0).
  - done←1, busy←0, state←IDLE.
- start while busy is ignored and is not queued. Changes to a or b after acceptance have no effect.
- Arithmetic: unsigned modulo 2^WIDTH. borrow is the inverted final carry. No signed-overflow flag.

## Timing
- Start accepted at edge k. busy is high from after edge k through after edge k+WIDTH−1.
- done, diff, borrow and zero update at edge k+WIDTH. done is high for exactly one cycle.
- Throughput: one result per WIDTH+1 cycles at most.
- start high in the cycle done is high: state is IDLE, so it is accepted at that edge. done drops and busy rises on the same edge. Back-to-back operations are legal.
- start held high continuously: a new operation starts each time the block returns to IDLE.
- Reset asserted mid-SHIFT clears everything immediately. After release, start is accepted at the first edge.
- Outputs are registered only. No combinational path from inputs to outputs.

## Test plan
- WIDTH=4, a=7, b=3, pulse start → done 4 cycles after acceptance; diff=4, borrow=0, zero=0; busy high for exactly 4 cycles.
- a=3, b=7 → diff=12 (4'b1100), borrow=1, zero=0.
- a=5, b=5 → diff=0, borrow=0, zero=1. Then a=0, b=15 → diff=1, borrow=1.
- a=9, b=2 accepted; 2 cycles later pulse start with a=1, b=1 → ignored; single done with diff=7; no second done.
- start held high with a=15, b=0 → done every 5 cycles, diff=15, borrow=0. Change a/b mid-operation → result uses the captured values.
- Accept a=8, b=1; assert rst after 2 SHIFT cycles → all outputs 0 immediately; no done. Release rst, start with a=2, b=3 → diff=15, borrow=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-adder cell computes a + ~b + 1 LSB-first,
// one bit per clock, then latches difference, borrow and zero flags.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s, cout, last, accept;

  function automatic logic fa_sum(input logic x, input logic y, input logic ci);
    return x ^ y ^ ci;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic ci);
    return (x & y) | (x & ci) | (y & ci);
  endfunction

  // Subtrahend bit is inverted into the adder; carry starts at 1 (two's complement)
  always_comb begin
    s         = fa_sum(a_sh[0], ~b_sh[0], carry);
    cout      = fa_carry(a_sh[0], ~b_sh[0], carry);
    res_nxt   = {s, res[WIDTH-1:1]};
    last      = (cnt == LAST);
    accept    = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        res   <= '0;
        carry <= 1'b1;
        cnt   <= '0;
        busy  <= 1'b1;
      end else if (state == SHIFT) begin
        carry <= cout;
        res   <= res_nxt;
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        cnt   <= cnt + 1'b1;
        // Final bit: publish result; borrow is the inverted carry-out
        if (last) begin
          diff   <= res_nxt;
          borrow <= ~cout;
          zero   <= (res_nxt == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
        end
      end
    end
  end

endmodule
